lut_fn_eval: RTL and testbench



---
 rtl/lut_fn_eval.sv | 111 +++++++++++
 tb/tb_lut_fn_eval.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lut_fn_eval.sv
// Programmable N_IN-input boolean function: truth table loaded serially, evaluated with a
// registered valid/ready stage.
module lut_fn_eval #(
  parameter int unsigned               N_IN       = 5,
  parameter logic [(2**N_IN)-1:0]      DEFAULT_TT = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cfg_start_i,
  input  logic            cfg_valid_i,
  input  logic            cfg_bit_i,
  output logic            cfg_done_o,
  output logic            busy_o,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [N_IN-1:0] x_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic            y_o
);

  localparam int unsigned Depth   = 2 ** N_IN;
  localparam logic [N_IN:0] LastIdx = (N_IN + 1)'(Depth - 1);

  typedef enum logic {StRun, StLoad} state_e;

  state_e            state_q, state_d;
  logic [Depth-1:0]  tt_q, tt_d;
  logic [Depth-1:0]  shadow_q, shadow_d;
  logic [N_IN:0]     cnt_q, cnt_d;
  logic              cfg_done_q, cfg_done_d;
  logic              out_valid_q, out_valid_d;
  logic              y_q, y_d;
  logic              accept;

  // Table load: bits collect in the shadow and only reach tt on the final bit.
  always_comb begin
    state_d    = state_q;
    tt_d       = tt_q;
    shadow_d   = shadow_q;
    cnt_d      = cnt_q;
    cfg_done_d = 1'b0;
    unique case (state_q)
      StRun: begin
        if (cfg_start_i) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        if (cfg_start_i) begin
          cnt_d = '0;
          if (cfg_valid_i) begin
            shadow_d[0] = cfg_bit_i;
            cnt_d       = (N_IN + 1)'(1);
          end
        end else if (cfg_valid_i) begin
          shadow_d[cnt_q[N_IN-1:0]] = cfg_bit_i;
          cnt_d                     = cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            tt_d       = {cfg_bit_i, shadow_q[Depth-2:0]};
            state_d    = StRun;
            cfg_done_d = 1'b1;
          end
        end
      end
      default: state_d = StRun;
    endcase
  end

  assign in_ready_o = (state_q == StRun) && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  // Evaluation uses the table as it stands before any same-cycle commit.
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    if (accept) begin
      y_d         = tt_q[x_i];
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      tt_q        <= DEFAULT_TT;
      shadow_q    <= '0;
      cnt_q       <= '0;
      cfg_done_q  <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      tt_q        <= tt_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      cfg_done_q  <= cfg_done_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
    end
  end

  assign busy_o      = (state_q == StLoad);
  assign cfg_done_o  = cfg_done_q;
  assign out_valid_o = out_valid_q;
  assign y_o         = y_q;

endmodule

// File: tb/tb_lut_fn_eval.sv
// Bench for lut_fn_eval: directed scenarios plus random traffic against a behavioural model.
module tb_lut_fn_eval;

  localparam logic [31:0] DefTt = 32'hA5A5_0F0F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_start = 1'b0, cfg_valid = 1'b0, cfg_bit = 1'b0;
  logic       cfg_done, busy, in_ready, out_valid, y;
  logic       in_valid = 1'b0, out_ready = 1'b1;
  logic [4:0] x = '0;

  int vectors = 0;
  int errors  = 0;
  int done_seen = 0;

  // Behavioural model state.
  bit          m_load;
  int          m_cnt;
  logic [31:0] m_shadow, m_tt;
  bit          m_ov, m_y, m_done;

  lut_fn_eval #(.N_IN(5), .DEFAULT_TT(DefTt)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cfg_start_i(cfg_start),
    .cfg_valid_i(cfg_valid),
    .cfg_bit_i  (cfg_bit),
    .cfg_done_o (cfg_done),
    .busy_o     (busy),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .x_i        (x),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .y_o        (y)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_load = 0; m_cnt = 0; m_shadow = '0; m_tt = DefTt; m_ov = 0; m_y = 0; m_done = 0;
  endtask

  // One clock cycle with the inputs currently driven; checks against the model.
  task automatic tick();
    bit exp_rdy;
    bit acc;
    #1;
    exp_rdy = !m_load && (!m_ov || out_ready);
    check_eq("in_ready", in_ready, exp_rdy);
    acc = in_valid && exp_rdy;
    m_done = 0;
    if (acc) begin
      m_y  = m_tt[x];
      m_ov = 1;
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (!m_load) begin
      if (cfg_start) begin
        m_load = 1;
        m_cnt  = 0;
      end
    end else if (cfg_start) begin
      m_cnt = 0;
      if (cfg_valid) begin
        m_shadow[0] = cfg_bit;
        m_cnt       = 1;
      end
    end else if (cfg_valid) begin
      m_shadow[m_cnt] = cfg_bit;
      m_cnt++;
      if (m_cnt == 32) begin
        m_tt   = m_shadow;
        m_load = 0;
        m_done = 1;
      end
    end
    @(posedge clk);
    #1;
    if (cfg_done === 1'b1) done_seen++;
    check_eq("out_valid", out_valid, m_ov);
    if (m_ov) check_eq("y", y, m_y);
    check_eq("busy", busy, m_load);
    check_eq("cfg_done", cfg_done, m_done);
  endtask

  task automatic idle_inputs();
    cfg_start = 0; cfg_valid = 0; cfg_bit = 0; in_valid = 0;
  endtask

  task automatic start_load();
    idle_inputs();
    cfg_start = 1;
    tick();
    cfg_start = 0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1; cfg_bit = v[i];
      tick();
    end
    cfg_valid = 0;
  endtask

  task automatic eval(input logic [4:0] xv);
    idle_inputs();
    in_valid = 1; x = xv;
    tick();
    in_valid = 0;
  endtask

  initial begin
    model_reset();
    #22 rst_n = 1;
    @(posedge clk); #1;

    // Reset state and default table.
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cfg_done", cfg_done, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    eval(5'd0);  check_eq("def_x0", y, 1);
    eval(5'd4);  check_eq("def_x4", y, 0);
    eval(5'd31); check_eq("def_x31", y, 1);
    tick();

    // Full serial load.
    done_seen = 0;
    start_load();
    send_bits(32'h8000_0001, 32);
    check_eq("load_done_cnt", done_seen, 1);
    eval(5'd0);  check_eq("ld_x0", y, 1);
    eval(5'd31); check_eq("ld_x31", y, 1);
    eval(5'd17); check_eq("ld_x17", y, 0);
    tick();

    // Backpressure.
    out_ready = 0;
    eval(5'd0);  check_eq("bp_y0", y, 1);
    in_valid = 1; x = 5'd17;
    tick();      check_eq("bp_hold", y, 1);
    check_eq("bp_stalled_rdy", in_ready, 0);
    out_ready = 1;
    tick();      check_eq("bp_x17", y, 0);
    in_valid = 0;
    tick();

    // Restart mid-load.
    done_seen = 0;
    start_load();
    send_bits(32'h0, 10);
    start_load();
    send_bits(32'hFFFF_FFFF, 32);
    check_eq("restart_done_cnt", done_seen, 1);
    for (int i = 0; i < 32; i++) begin
      eval(5'(i));
      check_eq("restart_sweep", y, 1);
    end
    tick();

    // Async reset mid-load with a result held under backpressure.
    out_ready = 0;
    idle_inputs();
    in_valid = 1; x = 5'd3; cfg_start = 1;
    tick();
    idle_inputs();
    send_bits(32'h0, 20);
    rst_n = 0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_out_valid", out_valid, 0);
    model_reset();
    #3 rst_n = 1;
    out_ready = 1;
    @(posedge clk); #1;
    eval(5'd0);  check_eq("arst_x0", y, DefTt[0]);
    tick();

    // cfg_start together with an accept uses the old table.
    start_load();
    send_bits(32'h8000_0000, 32);
    idle_inputs();
    in_valid = 1; x = 5'd31; cfg_start = 1;
    tick();      check_eq("start_acc_y", y, 1);
    idle_inputs();
    send_bits(32'h0, 32);
    eval(5'd31); check_eq("zero_x31", y, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      x         = 5'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_start = ($urandom_range(0, 99) == 0);
      cfg_valid = ($urandom_range(0, 2) != 0);
      cfg_bit   = 1'($urandom);
      tick();
    end
    idle_inputs();
    out_ready = 1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
